fetch_xlate_queue: RTL and testbench

Registers instruction-fetch translation results from the address-translation unit and checks them for fetch exceptions. Buffers the checked requests in a small FIFO and hands them to the instruction cache over a valid/ready handshake. Sits between the PC/fetch stage (with the combinational TLB/DMW lookup) and the icache request port. Decouples icache back-pressure from translation and stops fetch after the first faulting address until the pipeline flushes.

---
 rtl/fetch_xlate_queue.sv | 128 ++++++++++++
 tb/tb_fetch_xlate_queue.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_xlate_queue.sv
// Fetch translation queue: checks translated fetch addresses for exceptions and buffers them for the icache.
// Optional macro FETCH_ADEF_CHECK_EN enables the fetch address alignment (ADEF) check.
module fetch_xlate_queue #(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_vaddr,
  input  logic [19:0]                  in_tag,
  input  logic [7:0]                   in_index,
  input  logic [3:0]                   in_offset,
  input  logic                         in_direct,
  input  logic                         in_tlb_found,
  input  logic                         in_tlb_v,
  input  logic [1:0]                   in_tlb_plv,
  input  logic [1:0]                   in_mat,
  input  logic [1:0]                   csr_plv,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_vaddr,
  output logic [31:0]                  out_paddr,
  output logic                         out_uncached,
  output logic                         out_excp,
  output logic [5:0]                   out_ecode,
  output logic                         o_dbg_state,
  output logic [$clog2(DEPTH+1)-1:0]   o_dbg_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [5:0] ECODE_ADEF = 6'h08;
  localparam logic [5:0] ECODE_TLBR = 6'h3F;
  localparam logic [5:0] ECODE_PIF  = 6'h03;
  localparam logic [5:0] ECODE_PPI  = 6'h07;

  typedef enum logic {ST_RUN = 1'b0, ST_HOLD = 1'b1} state_t;

  state_t          r_state, w_state_nxt;
  logic [31:0]     r_vaddr [DEPTH];
  logic [31:0]     r_paddr [DEPTH];
  logic            r_unc   [DEPTH];
  logic            r_excp  [DEPTH];
  logic [5:0]      r_ecode [DEPTH];
  logic [PW-1:0]   r_wptr, r_rptr;
  logic [CW-1:0]   r_count;

  logic            w_adef, w_excp, w_push, w_pop;
  logic [5:0]      w_ecode;

  // Handshakes: a transfer happens on a cycle where valid && ready are both high at the
  // rising edge; flush cancels any transfer in its cycle. in_ready uses registered state only.
  assign in_ready  = (r_state == ST_RUN) && (r_count != FULL);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready && !flush;
  assign w_pop     = out_valid && out_ready && !flush;

  assign out_vaddr    = r_vaddr[r_rptr];
  assign out_paddr    = r_paddr[r_rptr];
  assign out_uncached = r_unc[r_rptr];
  assign out_excp     = r_excp[r_rptr];
  assign out_ecode    = r_ecode[r_rptr];
  assign o_dbg_state  = r_state;
  assign o_dbg_count  = r_count;

`ifdef FETCH_ADEF_CHECK_EN
  assign w_adef = (in_vaddr[1:0] != 2'b00);
`else
  assign w_adef = 1'b0;
`endif

  always_comb begin
    w_excp  = 1'b1;
    w_ecode = 6'h00;
    if (w_adef)                          w_ecode = ECODE_ADEF;
    else if (!in_direct && !in_tlb_found) w_ecode = ECODE_TLBR;
    else if (!in_direct && !in_tlb_v)     w_ecode = ECODE_PIF;
    else if (!in_direct && (csr_plv > in_tlb_plv)) w_ecode = ECODE_PPI;
    else                                 w_excp  = 1'b0;
  end

  // Fetch stops after the first faulting entry until the pipeline flushes.
  always_comb begin
    w_state_nxt = r_state;
    if (flush)                 w_state_nxt = ST_RUN;
    else if (w_push && w_excp) w_state_nxt = ST_HOLD;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_vaddr[i] <= '0;
        r_paddr[i] <= '0;
        r_unc[i]   <= 1'b0;
        r_excp[i]  <= 1'b0;
        r_ecode[i] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      if (flush) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) begin
          r_vaddr[r_wptr] <= in_vaddr;
          r_paddr[r_wptr] <= {in_tag, in_index, in_offset};
          r_unc[r_wptr]   <= (in_mat == 2'b00) && !w_excp;
          r_excp[r_wptr]  <= w_excp;
          r_ecode[r_wptr] <= w_ecode;
          r_wptr          <= r_wptr + PW'(1);
        end
        if (w_pop) r_rptr <= r_rptr + PW'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_fetch_xlate_queue.sv
// Testbench for fetch_xlate_queue: directed scenarios plus random traffic against a scoreboard queue.
module tb_fetch_xlate_queue;
  localparam int DEPTH = 2;
  localparam int W = 72;

  logic        clk, reset, flush;
  logic        in_valid, in_ready;
  logic [31:0] in_vaddr;
  logic [19:0] in_tag;
  logic [7:0]  in_index;
  logic [3:0]  in_offset;
  logic        in_direct, in_tlb_found, in_tlb_v;
  logic [1:0]  in_tlb_plv, in_mat, csr_plv;
  logic        out_valid, out_ready;
  logic [31:0] out_vaddr, out_paddr;
  logic        out_uncached, out_excp;
  logic [5:0]  out_ecode;
  logic        o_dbg_state;
  logic [1:0]  o_dbg_count;

  logic [W-1:0] exp_q[$];
  logic         m_hold;
  logic         mon_en;
  int           n_cmp, n_err;

  fetch_xlate_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_vaddr(in_vaddr),
    .in_tag(in_tag), .in_index(in_index), .in_offset(in_offset),
    .in_direct(in_direct), .in_tlb_found(in_tlb_found), .in_tlb_v(in_tlb_v),
    .in_tlb_plv(in_tlb_plv), .in_mat(in_mat), .csr_plv(csr_plv),
    .out_valid(out_valid), .out_ready(out_ready), .out_vaddr(out_vaddr),
    .out_paddr(out_paddr), .out_uncached(out_uncached), .out_excp(out_excp),
    .out_ecode(out_ecode), .o_dbg_state(o_dbg_state), .o_dbg_count(o_dbg_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference entry {vaddr, paddr, uncached, excp, ecode} for the current inputs.
  function automatic logic [W-1:0] model_entry();
    logic       excp;
    logic [5:0] ec;
    logic       adef;
    logic [31:0] va;
    va   = in_vaddr;
    adef = 1'b0;
`ifdef FETCH_ADEF_CHECK_EN
    adef = (va[1:0] != 2'b00);
`endif
    excp = 1'b1;
    ec   = 6'h00;
    if (adef) ec = 6'h08;
    else if (!in_direct && !in_tlb_found) ec = 6'h3F;
    else if (!in_direct && !in_tlb_v) ec = 6'h03;
    else if (!in_direct && csr_plv > in_tlb_plv) ec = 6'h07;
    else excp = 1'b0;
    return {in_vaddr, in_tag, in_index, in_offset, (in_mat == 2'b00) && !excp, excp, ec};
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      chk("in_ready", W'(in_ready), W'(!m_hold && exp_q.size() < DEPTH));
      chk("out_valid", W'(out_valid), W'(exp_q.size() != 0));
      if (out_valid && exp_q.size() != 0)
        chk("head", {out_vaddr, out_paddr, out_uncached, out_excp, out_ecode}, exp_q[0]);
      if (reset || flush) begin
        exp_q.delete();
        m_hold = 1'b0;
      end else begin
        if (out_valid && out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
        if (in_valid && in_ready) begin
          logic [W-1:0] e;
          e = model_entry();
          exp_q.push_back(e);
          if (e[6]) m_hold = 1'b1;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input logic [31:0] va, input logic [19:0] tg, input logic [7:0] ix,
                         input logic [3:0] of, input logic dir, input logic fnd, input logic v,
                         input logic [1:0] tplv, input logic [1:0] mat, input logic [1:0] cplv);
    in_vaddr = va; in_tag = tg; in_index = ix; in_offset = of;
    in_direct = dir; in_tlb_found = fnd; in_tlb_v = v;
    in_tlb_plv = tplv; in_mat = mat; csr_plv = cplv;
    in_valid = 1'b1;
  endtask

  // Holds the request until accepted; returns 1 ns after the accepting edge.
  task automatic send(input logic [31:0] va, input logic [19:0] tg, input logic [7:0] ix,
                      input logic [3:0] of, input logic dir, input logic fnd, input logic v,
                      input logic [1:0] tplv, input logic [1:0] mat, input logic [1:0] cplv);
    logic acc;
    set_req(va, tg, ix, of, dir, fnd, v, tplv, mat, cplv);
    acc = 1'b0;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk);
      acc = in_ready && !flush;
      @(posedge clk); #1;
    end
    if (!acc) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic wait_empty();
    int t;
    for (t = 0; t < 50; t++) begin
      @(negedge clk);
      if (!out_valid) break;
    end
    if (t == 50) chk("drain_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_cmp = 0; n_err = 0; mon_en = 1'b0; m_hold = 1'b0;
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    set_req(32'h0, 20'h0, 8'h0, 4'h0, 1'b1, 1'b1, 1'b1, 2'd0, 2'd1, 2'd0);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // reset state
    chk("rst_out_valid", W'(out_valid), 0);
    chk("rst_in_ready", W'(in_ready), 1);
    chk("rst_vaddr", W'(out_vaddr), 0);
    chk("rst_paddr", W'(out_paddr), 0);
    chk("rst_flags", W'({out_uncached, out_excp, out_ecode}), 0);
    chk("rst_state", W'(o_dbg_state), 0);
    mon_en = 1'b1;

    // direct-mapped cached fetch, one-cycle latency
    out_ready = 1'b1;
    send(32'h1C000000, 20'h1C000, 8'h00, 4'h0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd1, 2'd0);
    @(negedge clk);
    chk("first_valid", W'(out_valid), 1);
    chk("first_paddr", W'(out_paddr), 72'h1C000000);
    chk("first_flags", W'({out_uncached, out_excp}), 0);
    @(posedge clk); #1;

    // back-pressure fills the queue, third request waits for a dequeue
    out_ready = 1'b0;
    fork
      begin
        send(32'h00001000, 20'h00011, 8'h22, 4'h0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0);
        send(32'h00001010, 20'h00011, 8'h22, 4'h4, 1'b1, 1'b0, 1'b0, 2'd0, 2'd1, 2'd0);
        send(32'h00001020, 20'h00033, 8'h44, 4'h8, 1'b0, 1'b1, 1'b1, 2'd3, 2'd2, 2'd0);
      end
      begin
        repeat (3) @(posedge clk); #1;
        chk("full_in_ready", W'(in_ready), 0);
        chk("full_count", W'(o_dbg_count), 2);
        @(posedge clk); #1;
        chk("full_stable_vaddr", W'(out_vaddr), 72'h00001000);
        out_ready = 1'b1;
      end
    join
    wait_empty();

    // TLB refill fault holds fetch until flush
    send(32'h00400000, 20'h00400, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd0);
    @(negedge clk);
    chk("tlbr_excp", W'({out_excp, out_ecode}), W'({1'b1, 6'h3F}));
    chk("tlbr_unc", W'(out_uncached), 0);
    in_vaddr = 32'h00400004; in_valid = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("hold_in_ready", W'(in_ready), 0);
    chk("hold_state", W'(o_dbg_state), 1);
    in_valid = 1'b0;
    do_flush();
    chk("post_flush_ready", W'(in_ready), 1);

    // PPI, then PIF beating PPI
    send(32'h00500000, 20'h00500, 8'h00, 4'h0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd1, 2'd3);
    @(negedge clk);
    chk("ppi_ecode", W'({out_excp, out_ecode}), W'({1'b1, 6'h07}));
    @(posedge clk); #1;
    do_flush();
    send(32'h00600000, 20'h00600, 8'h00, 4'h0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd1, 2'd3);
    @(negedge clk);
    chk("pif_ecode", W'({out_excp, out_ecode}), W'({1'b1, 6'h03}));
    @(posedge clk); #1;
    do_flush();

    // misaligned fetch address
    send(32'h00000002, 20'h00ABC, 8'h5D, 4'h2, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0);
    @(negedge clk);
`ifdef FETCH_ADEF_CHECK_EN
    chk("adef_ecode", W'({out_excp, out_ecode}), W'({1'b1, 6'h08}));
`else
    chk("noadef_excp", W'({out_excp, out_ecode}), 0);
    chk("noadef_paddr", W'(out_paddr), 72'h00ABC5D2);
    chk("noadef_unc", W'(out_uncached), 1);
`endif
    @(posedge clk); #1;
    do_flush();

    // flush with a full queue and a pending request
    out_ready = 1'b0;
    send(32'h00002000, 20'h00002, 8'h00, 4'h0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd1, 2'd0);
    send(32'h00002004, 20'h00002, 8'h00, 4'h4, 1'b1, 1'b0, 1'b0, 2'd0, 2'd1, 2'd0);
    set_req(32'h00002008, 20'h00002, 8'h00, 4'h8, 1'b1, 1'b0, 1'b0, 2'd0, 2'd1, 2'd0);
    do_flush();
    in_valid = 1'b0;
    chk("flfull_valid", W'(out_valid), 0);
    chk("flfull_count", W'(o_dbg_count), 0);
    chk("flfull_ready", W'(in_ready), 1);
    // flush with room in the queue still drops the same-cycle request
    send(32'h00003000, 20'h00003, 8'h00, 4'h0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd1, 2'd0);
    set_req(32'h00003004, 20'h00003, 8'h00, 4'h4, 1'b1, 1'b0, 1'b0, 2'd0, 2'd1, 2'd0);
    do_flush();
    in_valid = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("flpart_valid", W'(out_valid), 0);
    chk("flpart_count", W'(o_dbg_count), 0);

    // random traffic
    for (int c = 0; c < 400; c++) begin
      in_valid     = ($urandom_range(0, 3) != 0);
      in_vaddr     = $urandom();
      in_tag       = 20'($urandom());
      in_index     = 8'($urandom());
      in_offset    = 4'($urandom());
      in_direct    = ($urandom_range(0, 1) == 1);
      in_tlb_found = ($urandom_range(0, 7) != 0);
      in_tlb_v     = ($urandom_range(0, 7) != 0);
      in_tlb_plv   = 2'($urandom_range(0, 3));
      in_mat       = 2'($urandom_range(0, 3));
      csr_plv      = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) in_vaddr[1:0] = 2'b00;
      out_ready    = ($urandom_range(0, 2) != 0);
      flush        = ($urandom_range(0, 19) == 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    do_flush();

    // reset mid-operation zeroes storage
    out_ready = 1'b0;
    send(32'h0000ABC0, 20'h12345, 8'h67, 4'h8, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0);
    send(32'h0000ABC4, 20'h12345, 8'h67, 4'hC, 1'b1, 1'b0, 1'b0, 2'd0, 2'd1, 2'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_rst_valid", W'(out_valid), 0);
    chk("mid_rst_ready", W'(in_ready), 1);
    chk("mid_rst_vaddr", W'(out_vaddr), 0);
    chk("mid_rst_paddr", W'(out_paddr), 0);
    chk("mid_rst_flags", W'({out_uncached, out_excp, out_ecode}), 0);
    repeat (2) @(posedge clk); #1;

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
